beamformer_sequencer: RTL and testbench
=======================================

BEAMFORMER_SEQUENCER -- requirements
Module: beamformer_sequencer

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 64, meaning delayed samples summed per scan line (2..1024).
REQ-002 SHALL have parameter MAX_INDEX, default 16'd4095, meaning the last legal sample index in one line.
REQ-003 SHALL have parameter SAMPLE_W, default 12, meaning the sample width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a scan line.
REQ-007 abort  in  1  terminate the current line immediately.
REQ-008 sample_valid  in  1  new ADC sample presented this cycle.
REQ-009 bf_index  out  16  sample index driven to the beamformer input_index.
REQ-010 bf_start  out  1  enable driven to the beamformer startbeamformer.
REQ-011 bf_value  in  SAMPLE_W  beamformer output_value.
REQ-012 bf_data_good  in  1  beamformer data_good; bf_value is a selected tap.
REQ-013 sum_out  out  SAMPLE_W+clog2(NUM_TAPS)  delay-and-sum result.
REQ-014 sum_valid  out  1  one-cycle pulse; sum_out is a complete line.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky flag; the line ended before NUM_TAPS taps were collected.

Function
REQ-017 SHALL implement an FSM with states IDLE, CLEAR, RUN, DONE and FAIL, with all outputs registered.
REQ-018 In IDLE, start SHALL move the FSM to CLEAR.
- start in any other state SHALL be ignored.
REQ-019 CLEAR SHALL last exactly 1 cycle and SHALL:
- zero the accumulator, tap_count and bf_index;
- clear timeout_err;
- then enter RUN.
REQ-020 bf_start SHALL be 1 only in RUN, first asserted 2 cycles after the start pulse.
REQ-021 In RUN, each sample_valid SHALL increment bf_index by 1 on the following edge.
REQ-022 In RUN, bf_data_good SHALL add zero-extended bf_value to the accumulator and increment tap_count.
- This applies in the same cycle as any sample_valid; the two are independent.
REQ-023 When a data_good makes tap_count equal NUM_TAPS, the FSM SHALL enter DONE.
- Any later data_good in that cycle window SHALL be ignored.
REQ-024 DONE SHALL last 1 cycle, with sum_valid=1 and sum_out = final accumulator, then return to IDLE.
REQ-025 sum_out SHALL hold its value until the next CLEAR.
REQ-026 If sample_valid arrives in RUN with bf_index == MAX_INDEX and tap_count < NUM_TAPS, the FSM SHALL enter FAIL.
- bf_index SHALL NOT wrap.
REQ-027 FAIL SHALL last 1 cycle, set timeout_err=1, keep sum_valid=0, then return to IDLE.
REQ-028 If that final sample_valid coincides with the data_good completing NUM_TAPS, completion SHALL win (DONE).
REQ-029 abort in CLEAR, RUN, DONE or FAIL SHALL force IDLE on the next edge.
- bf_start and sum_valid SHALL then be 0.
- abort SHALL have priority over completion and FAIL.
- The accumulator SHALL NOT be cleared by abort.
REQ-030 The accumulator SHALL be unsigned, SAMPLE_W+clog2(NUM_TAPS) bits wide, and overflow-free by construction.
REQ-031 bf_start SHALL be low for at least 1 cycle between consecutive lines, so the beamformer's tap pointer sequence restarts cleanly.

Reset
REQ-032 reset SHALL force:
- the FSM to IDLE;
- bf_index, tap_count, the accumulator and sum_out to 0;
- bf_start, sum_valid, busy and timeout_err to 0.
REQ-033 reset SHALL take priority over start, abort and all inputs, including mid-line.

Structure
REQ-034 The FSM state enum, the default NUM_TAPS/MAX_INDEX/SAMPLE_W values and the sum-width function SHALL reside in shared package bf_pkg.
REQ-035 No sub-module SHALL be instantiated.
- Counters and the accumulator are inline.
- The beamformer is connected at the level above.

Verification
REQ-036 NUM_TAPS=4, start, sample_valid every cycle, data_good with bf_value 10,20,30,40 -> sum_valid pulse, sum_out=100, busy falls the next cycle.
REQ-037 start at cycle 0 -> busy=1 at cycle 1, bf_start=1 at cycle 2; start repeated at cycle 3 -> ignored, bf_index unaffected.
REQ-038 MAX_INDEX=7, 2 data_goods, 8 sample_valids -> FAIL, timeout_err=1, no sum_valid; next start clears timeout_err.
REQ-039 abort in RUN after 2 taps, same cycle as data_good -> IDLE next cycle, bf_start=0, sum_valid never asserted.
REQ-040 Final tap data_good coincident with sample_valid at bf_index==MAX_INDEX -> DONE, not FAIL.
REQ-041 reset asserted mid-RUN -> all outputs 0 next cycle; then full line of 4 taps of 4095 -> sum_out=16380.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the beamformer scan-line sequencer.
package bf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE,
        ST_FAIL
    } bf_state_t;

    localparam int unsigned BF_NUM_TAPS  = 64;
    localparam logic [15:0] BF_MAX_INDEX = 16'd4095;
    localparam int unsigned BF_SAMPLE_W  = 12;

    // Accumulator width that cannot overflow when summing num_taps full-scale samples.
    function automatic int unsigned bf_sum_width(input int unsigned sample_w,
                                                 input int unsigned num_taps);
        return sample_w + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/beamformer_sequencer.sv
// Scan-line sequencer: drives the beamformer sample index, collects NUM_TAPS
// selected taps into a delay-and-sum accumulator and reports completion or
// index exhaustion.
module beamformer_sequencer
    import bf_pkg::*;
#(
    parameter int unsigned NUM_TAPS  = BF_NUM_TAPS,
    parameter logic [15:0] MAX_INDEX = BF_MAX_INDEX,
    parameter int unsigned SAMPLE_W  = BF_SAMPLE_W
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic                                        abort,
    input  logic                                        sample_valid,
    output logic [15:0]                                 bf_index,
    output logic                                        bf_start,
    input  logic [SAMPLE_W-1:0]                         bf_value,
    input  logic                                        bf_data_good,
    output logic [bf_sum_width(SAMPLE_W, NUM_TAPS)-1:0] sum_out,
    output logic                                        sum_valid,
    output logic                                        busy,
    output logic                                        timeout_err
);

    localparam int unsigned      SUM_W    = bf_sum_width(SAMPLE_W, NUM_TAPS);
    localparam int unsigned      CNT_W    = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS - 1);
    localparam logic [CNT_W-1:0] ALL_TAPS = CNT_W'(NUM_TAPS);

    bf_state_t        r_state;
    bf_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_tap_count;
    logic [SUM_W-1:0] r_acc;
    logic [SUM_W-1:0] r_sum_out;
    logic [15:0]      r_bf_index;
    logic             r_bf_start;
    logic             r_sum_valid;
    logic             r_busy;
    logic             r_timeout_err;

    logic             w_run;
    logic             w_tap;
    logic             w_complete;
    logic             w_overrun;
    logic [SUM_W-1:0] w_acc_add;
    logic             w_busy_nxt;
    logic             w_bf_start_nxt;
    logic             w_sum_valid_nxt;

    assign w_run      = (r_state == ST_RUN);
    assign w_tap      = w_run && bf_data_good;
    assign w_complete = w_tap && (r_tap_count == LAST_TAP);
    assign w_overrun  = w_run && sample_valid && (r_bf_index == MAX_INDEX)
                        && (r_tap_count < ALL_TAPS);
    assign w_acc_add  = r_acc + SUM_W'(bf_value);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the next value of every state-derived output.
    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = 1'b0;
        w_bf_start_nxt  = 1'b0;
        w_sum_valid_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Abort beats completion, and completion beats index exhaustion.
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_complete) begin
                    w_state_nxt = ST_DONE;
                end else if (w_overrun) begin
                    w_state_nxt = ST_FAIL;
                end
            end
            ST_DONE, ST_FAIL: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_bf_start_nxt  = (w_state_nxt == ST_RUN);
        w_sum_valid_nxt = (w_state_nxt == ST_DONE);
    end

    // Datapath: index/tap counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap_count   <= '0;
            r_acc         <= '0;
            r_sum_out     <= '0;
            r_bf_index    <= '0;
            r_bf_start    <= 1'b0;
            r_sum_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_bf_start  <= w_bf_start_nxt;
            r_sum_valid <= w_sum_valid_nxt;
            if (w_state_nxt == ST_CLEAR) begin
                // Clearing on entry so CLEAR itself already shows a fresh line.
                r_tap_count   <= '0;
                r_acc         <= '0;
                r_sum_out     <= '0;
                r_bf_index    <= '0;
                r_timeout_err <= 1'b0;
            end else if (w_run && !abort) begin
                // An aborting cycle contributes nothing; the accumulator keeps its value.
                if (sample_valid && (r_bf_index != MAX_INDEX)) begin
                    r_bf_index <= r_bf_index + 16'd1;
                end
                if (w_tap) begin
                    r_acc       <= w_acc_add;
                    r_tap_count <= r_tap_count + CNT_W'(1);
                end
                if (w_complete) begin
                    r_sum_out <= w_acc_add;
                end
                if (w_state_nxt == ST_FAIL) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

    assign bf_index    = r_bf_index;
    assign bf_start    = r_bf_start;
    assign sum_out     = r_sum_out;
    assign sum_valid   = r_sum_valid;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_beamformer_sequencer.sv
// Scoreboarded bench for beamformer_sequencer (4 taps, last index 7).
module tb_beamformer_sequencer;

    localparam int unsigned T    = 4;
    localparam int unsigned MAXI = 7;
    localparam int unsigned OW   = 14;
    localparam int          LMAX = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic          sample_valid;
    logic [15:0]   bf_index;
    logic          bf_start;
    logic [11:0]   bf_value;
    logic          bf_data_good;
    logic [OW-1:0] sum_out;
    logic          sum_valid;
    logic          busy;
    logic          timeout_err;

    beamformer_sequencer #(
        .NUM_TAPS (T),
        .MAX_INDEX(16'd7),
        .SAMPLE_W (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .sample_valid(sample_valid),
        .bf_index    (bf_index),
        .bf_start    (bf_start),
        .bf_value    (bf_value),
        .bf_data_good(bf_data_good),
        .sum_out     (sum_out),
        .sum_valid   (sum_valid),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fail;
        int unsigned sum;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    bit          l_sv [LMAX];
    bit          l_dg [LMAX];
    bit          l_st [LMAX];
    int unsigned l_val[LMAX];

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic clear_line();
        for (int c = 0; c < LMAX; c++) begin
            l_sv[c]  = 1'b0;
            l_dg[c]  = 1'b0;
            l_st[c]  = 1'b0;
            l_val[c] = 0;
        end
    endtask

    task automatic drive_idle();
        start        = 1'b0;
        abort        = 1'b0;
        sample_valid = 1'b0;
        bf_data_good = 1'b0;
        bf_value     = '0;
    endtask

    // Reference: walk the RUN cycles counting taps and samples; abort wins,
    // then the NUM_TAPS-th tap, then a sample arriving with the index already at the end.
    task automatic do_line(input int abort_at);
        int          taps    = 0;
        int unsigned samples = 0;
        int unsigned sum     = 0;
        int          end_c   = -1;
        int          kind    = 0;
        int unsigned idx_at[LMAX];
        exp_t        e;
        for (int c = 0; c < LMAX; c++) begin
            idx_at[c] = samples;
            if (abort_at == c) begin
                kind = 0; end_c = c; break;
            end
            if (l_dg[c]) begin
                taps++;
                sum += l_val[c];
            end
            if (taps == T) begin
                kind = 1; end_c = c; break;
            end
            if (l_sv[c]) begin
                if (samples == MAXI) begin
                    kind = 2; end_c = c; break;
                end
                samples++;
            end
        end
        if (end_c < 0) begin
            checks++;
            failures++;
            $display("FAIL model_no_end: stimulus line never terminates");
            return;
        end
        if (kind != 0) begin
            e.is_fail = (kind == 2);
            e.sum     = sum;
            exp_q.push_back(e);
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        chk("clear_busy", busy, 1);
        chk("clear_bf_start", bf_start, 0);
        chk("clear_timeout_err", timeout_err, 0);
        start = 1'b0;
        for (int c = 0; c <= end_c; c++) begin
            @(negedge clk);
            chk("run_bf_start", bf_start, 1);
            chk("run_bf_index", bf_index, idx_at[c]);
            sample_valid = l_sv[c];
            bf_data_good = l_dg[c];
            bf_value     = 12'(l_val[c]);
            start        = l_st[c];
            abort        = (c == abort_at);
        end
        @(negedge clk);
        drive_idle();
        chk("end_bf_start", bf_start, 0);
        case (kind)
            0: begin
                chk("abort_busy", busy, 0);
                chk("abort_sum_valid", sum_valid, 0);
            end
            1: begin
                chk("done_busy", busy, 1);
                chk("done_sum_valid", sum_valid, 1);
            end
            default: begin
                chk("fail_timeout_err", timeout_err, 1);
                chk("fail_sum_valid", sum_valid, 0);
                chk("fail_busy", busy, 1);
            end
        endcase
        @(negedge clk);
        chk("after_busy", busy, 0);
        chk("after_sum_valid", sum_valid, 0);
        if (kind == 1) chk("sum_hold", sum_out, sum);
        if (kind == 2) chk("timeout_sticky", timeout_err, 1);
    endtask

    // Monitor: every completion or new timeout must match the oldest pending line.
    bit prev_to = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t m;
        if (sum_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_sum: sum_valid with no line pending, sum_out=%0d", sum_out);
            end else begin
                m = exp_q.pop_front();
                if (m.is_fail || (sum_out != m.sum)) begin
                    failures++;
                    $display("FAIL sb_sum: got done sum=%0d, expected fail=%0d sum=%0d",
                             sum_out, m.is_fail, m.sum);
                end
            end
        end
        if (timeout_err && !prev_to) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_timeout: timeout_err rose with no line pending");
            end else begin
                m = exp_q.pop_front();
                if (!m.is_fail) begin
                    failures++;
                    $display("FAIL sb_timeout: got timeout, expected done sum=%0d", m.sum);
                end
            end
        end
        prev_to = timeout_err;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ab;
        reset = 1'b1;
        drive_idle();
        repeat (3) @(negedge clk);
        chk("rst_bf_index", bf_index, 0);
        chk("rst_bf_start", bf_start, 0);
        chk("rst_sum_out", sum_out, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // Four taps 10..40, sample every cycle, a stray start on the second RUN cycle.
        clear_line();
        for (int c = 0; c < 4; c++) begin
            l_sv[c]  = 1'b1;
            l_dg[c]  = 1'b1;
            l_val[c] = 10 * (c + 1);
        end
        l_st[1] = 1'b1;
        do_line(-1);

        // Two taps, eight samples: index runs out.
        clear_line();
        for (int c = 0; c < 8; c++) l_sv[c] = 1'b1;
        l_dg[0] = 1'b1; l_val[0] = 7;
        l_dg[1] = 1'b1; l_val[1] = 9;
        do_line(-1);

        // Abort together with the third tap.
        clear_line();
        for (int c = 0; c < 3; c++) begin
            l_dg[c]  = 1'b1;
            l_val[c] = 100 + c;
        end
        do_line(2);

        // Last tap lands on the same cycle as the sample at the final index.
        clear_line();
        for (int c = 0; c < 8; c++) l_sv[c] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            l_dg[c]  = 1'b1;
            l_val[c] = 1000 + c;
        end
        l_dg[7] = 1'b1; l_val[7] = 55;
        do_line(-1);

        // Reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1; bf_data_good = 1'b1; bf_value = 12'd5;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_bf_index", bf_index, 0);
        chk("midrst_bf_start", bf_start, 0);
        chk("midrst_sum_out", sum_out, 0);
        chk("midrst_sum_valid", sum_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        reset = 1'b0;
        drive_idle();
        @(negedge clk);

        // Full-scale line.
        clear_line();
        for (int c = 0; c < 4; c++) begin
            l_sv[c]  = 1'b1;
            l_dg[c]  = 1'b1;
            l_val[c] = 4095;
        end
        do_line(-1);

        // Randomised lines.
        for (int n = 0; n < 40; n++) begin
            clear_line();
            for (int c = 0; c < LMAX; c++) begin
                l_sv[c]  = (c >= 40) ? 1'b1 : ($urandom_range(0, 1) == 1);
                l_dg[c]  = ($urandom_range(0, 2) == 0);
                l_val[c] = ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 4095);
                l_st[c]  = ($urandom_range(0, 7) == 0);
            end
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 12)) : -1;
            do_line(ab);
        end

        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
